lsu_access_ctrl: RTL
====================

// Module: lsu_access_ctrl
// PURPOSE
//  Data-stage load/store sequencer between the MEM pipeline stage and a req/gnt/rvalid data-memory port.
//  Latches one access and drives the bus transaction, holding the pipeline with stall until it completes.
//  Handles lane alignment, byte strobes and load sign/zero extension for LB/LH/LW/LBU/LHU/SB/SH/SW.
//  Reports misaligned, illegal-funct3 and timeout faults.
// PARAMETERS
//  TIMEOUT  default 64  cycles in REQ+RESP before bus fault; 0 disables the timeout
//  CNT_W    default 8   width of the timeout counter; requires 2**CNT_W > TIMEOUT
// PORTS
//  clk        in   1   single clock, rising edge
//  rst        in   1   asynchronous, active-high reset
//  ex_valid   in   1   MEM stage presents a load/store this cycle
//  ex_we      in   1   1 = store, 0 = load
//  ex_funct3  in   3   RV32I load/store funct3
//  ex_addr    in   32  byte address
//  ex_wdata   in   32  store data, right-justified
//  stall      out  1   freeze pipeline (combinational)
//  done       out  1   one-cycle pulse: access finished, pipeline may advance
//  fault      out  2   valid with done: 00 ok, 01 misaligned, 10 timeout, 11 illegal funct3
//  rdata      out  32  extended load result, valid with done
//  mem_req    out  1   bus request, held until mem_gnt
//  mem_we     out  1   bus write enable
//  mem_addr   out  32  word address: {ex_addr[31:2], 2'b00}
//  mem_wstrb  out  4   byte strobes; 0000 on loads
//  mem_wdata  out  32  store data shifted into its byte lane
//  mem_gnt    in   1   request accepted this cycle
//  mem_rvalid in   1   response/write-ack this cycle, at least 1 cycle after gnt
//  mem_rdata  in   32  read word, valid with mem_rvalid
// BEHAVIOUR
//  Reset: state IDLE; all outputs 0; counter 0; latched request cleared.
//  FSM states: IDLE, REQ, RESP, DONE.
//   IDLE, ex_valid=0: stay in IDLE.
//   IDLE, ex_valid=1: latch we/funct3/addr/wdata.
//    Legal and aligned: go to REQ.
//    Otherwise: go to DONE with fault=11 (illegal funct3) or fault=01 (misaligned); no bus activity.
//   REQ: mem_req=1 with registered bus fields; on mem_gnt go to RESP.
//   RESP: on mem_rvalid capture mem_rdata (loads) and go to DONE with fault=00.
//   REQ/RESP: when the counter reaches TIMEOUT, drop mem_req, go to DONE with fault=10 and rdata=0.
//   DONE: done=1 for one cycle, then return to IDLE.
//  Ordering: illegal funct3 has priority over misaligned. Illegal = 011, 110, 111, or a store with funct3[2]=1.
//  Alignment: a half access needs addr[0]=0; a word access needs addr[1:0]=00.
//  Stall: stall = (state==IDLE && ex_valid) | state==REQ | state==RESP. Low in DONE.
//  Latency: no wait states -> done is 3 cycles after the capture edge.
//   Each gnt or rvalid wait cycle adds one cycle.
//  Store lanes: wstrb = 0001 (byte), 0011 (half) or 1111 (word), shifted left by addr[1:0];
//   wdata = replicated byte/half positioned in the addressed lane.
//  Loads: shift mem_rdata right by 8*addr[1:0], then extend.
//   funct3[2]=0 sign-extends bit 7 (byte) or bit 15 (half); funct3[2]=1 zero-extends.
//  ex_* inputs are ignored outside IDLE; the latched copy rules the access.
//   Deasserting ex_valid mid-access does not abort it.
//  mem_rvalid in IDLE/REQ/DONE is ignored. mem_gnt outside REQ is ignored.
//  Async reset mid-access: mem_req drops immediately and the FSM returns to IDLE.
//   A late mem_rvalid from the aborted access is discarded.
//  Counter: clears on entry to REQ and increments each cycle in REQ/RESP.
// STRUCTURE
//  lsu_pkg holds: funct3 constants (LB..SW), fault_e {OK, MISALIGN, TIMEOUT, ILLEGAL},
//   state_e {IDLE, REQ, RESP, DONE}.
//  Sub-module lsu_lane_align (combinational) provides the legality/alignment check, wstrb/wdata
//   lane shift and rdata shift+extend. The top level holds the FSM, latches and counter.
// TESTING
//  1. LB addr=0x103, rdata=0x80FF_FF_FF, gnt/rvalid with no wait -> done 3 cycles after capture,
//     rdata=0xFFFFFF80, fault=00.
//  2. LHU addr=0x102, rdata=0x8001_xxxx -> rdata=0x00008001. LH on the same word -> 0xFFFF8001.
//  3. SB addr=0x201, wdata=0x12345678 -> mem_wstrb=0010, mem_wdata[15:8]=0x78, mem_addr=0x200.
//  4. LW addr=0x102 -> done next cycle after capture, fault=01, mem_req never asserted.
//     funct3=011 -> fault=11.
//  5. TIMEOUT=4, mem_gnt held 0 -> mem_req drops and done asserts with fault=10, rdata=0;
//     stall high throughout.
//  6. Assert rst while in RESP, then pulse mem_rvalid -> FSM in IDLE, done never pulses,
//     outputs all 0.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared types and constants for the data-stage load/store sequencer.
package lsu_pkg;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  typedef enum logic [1:0] {
    FaultOk       = 2'b00,
    FaultMisalign = 2'b01,
    FaultTimeout  = 2'b10,
    FaultIllegal  = 2'b11
  } fault_e;

  typedef enum logic [1:0] {
    StIdle = 2'b00,
    StReq  = 2'b01,
    StResp = 2'b10,
    StDone = 2'b11
  } state_e;

endpackage

// File: rtl/lsu_lane_align.sv
// Combinational legality check, store lane placement and load shift/extend.
module lsu_lane_align
  import lsu_pkg::*;
(
  input  logic        we_i,
  input  logic [2:0]  funct3_i,
  input  logic [1:0]  offset_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] mem_rdata_i,
  output fault_e      fault_o,
  output logic [3:0]  wstrb_o,
  output logic [31:0] wdata_o,
  output logic [31:0] rdata_o
);

  logic        illegal;
  logic        misalign;
  logic [3:0]  strb_base;
  logic [31:0] shifted;

  always_comb begin
    illegal  = (funct3_i == 3'b011) || (funct3_i == 3'b110) || (funct3_i == 3'b111) ||
               (we_i && funct3_i[2]);
    misalign = ((funct3_i[1:0] == 2'b01) && offset_i[0]) ||
               ((funct3_i[1:0] == 2'b10) && (offset_i != 2'b00));
    if (illegal) begin
      fault_o = FaultIllegal;
    end else if (misalign) begin
      fault_o = FaultMisalign;
    end else begin
      fault_o = FaultOk;
    end

    // Replicating the narrow datum puts it in every lane; the strobe picks the live one.
    case (funct3_i[1:0])
      2'b00: begin
        strb_base = 4'b0001;
        wdata_o   = {4{wdata_i[7:0]}};
      end
      2'b01: begin
        strb_base = 4'b0011;
        wdata_o   = {2{wdata_i[15:0]}};
      end
      default: begin
        strb_base = 4'b1111;
        wdata_o   = wdata_i;
      end
    endcase
    wstrb_o = we_i ? (strb_base << offset_i) : 4'b0000;

    shifted = mem_rdata_i >> {offset_i, 3'b000};
    case (funct3_i[1:0])
      2'b00:   rdata_o = {{24{~funct3_i[2] & shifted[7]}}, shifted[7:0]};
      2'b01:   rdata_o = {{16{~funct3_i[2] & shifted[15]}}, shifted[15:0]};
      default: rdata_o = shifted;
    endcase
  end

endmodule

// File: rtl/lsu_access_ctrl.sv
// Load/store sequencer: latches one MEM-stage access and runs it on a req/gnt/rvalid port.
module lsu_access_ctrl
  import lsu_pkg::*;
#(
  parameter int unsigned TIMEOUT = 64,
  parameter int unsigned CNT_W   = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ex_valid,
  input  logic        ex_we,
  input  logic [2:0]  ex_funct3,
  input  logic [31:0] ex_addr,
  input  logic [31:0] ex_wdata,
  output logic        stall,
  output logic        done,
  output logic [1:0]  fault,
  output logic [31:0] rdata,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_wstrb,
  output logic [31:0] mem_wdata,
  input  logic        mem_gnt,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata
);

  state_e      state_q, state_d;
  logic        we_q, we_d;
  logic [2:0]  f3_q, f3_d;
  logic [1:0]  off_q, off_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic        mem_req_q, mem_req_d;
  logic        mem_we_q, mem_we_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic [3:0]  mem_wstrb_q, mem_wstrb_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;
  fault_e      fault_q, fault_d;
  logic [31:0] rdata_q, rdata_d;

  logic        idle;
  fault_e      lane_fault;
  logic [3:0]  lane_wstrb;
  logic [31:0] lane_wdata;
  logic [31:0] lane_rdata;
  logic        timeout_hit;

  assign idle = (state_q == StIdle);

  // In IDLE the aligner judges the incoming access; afterwards it serves the latched copy.
  lsu_lane_align u_lane_align (
    .we_i        (idle ? ex_we : we_q),
    .funct3_i    (idle ? ex_funct3 : f3_q),
    .offset_i    (idle ? ex_addr[1:0] : off_q),
    .wdata_i     (ex_wdata),
    .mem_rdata_i (mem_rdata),
    .fault_o     (lane_fault),
    .wstrb_o     (lane_wstrb),
    .wdata_o     (lane_wdata),
    .rdata_o     (lane_rdata)
  );

  assign timeout_hit = (TIMEOUT != 0) && (cnt_q == CNT_W'(TIMEOUT - 1));

  always_comb begin
    state_d     = state_q;
    we_d        = we_q;
    f3_d        = f3_q;
    off_d       = off_q;
    cnt_d       = cnt_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wstrb_d = mem_wstrb_q;
    mem_wdata_d = mem_wdata_q;
    fault_d     = fault_q;
    rdata_d     = rdata_q;
    unique case (state_q)
      StIdle: begin
        if (ex_valid) begin
          we_d  = ex_we;
          f3_d  = ex_funct3;
          off_d = ex_addr[1:0];
          if (lane_fault == FaultOk) begin
            state_d     = StReq;
            cnt_d       = '0;
            mem_req_d   = 1'b1;
            mem_we_d    = ex_we;
            mem_addr_d  = {ex_addr[31:2], 2'b00};
            mem_wstrb_d = lane_wstrb;
            mem_wdata_d = lane_wdata;
          end else begin
            state_d = StDone;
            fault_d = lane_fault;
            rdata_d = '0;
          end
        end
      end
      StReq: begin
        cnt_d = cnt_q + 1'b1;
        if (mem_gnt) begin
          mem_req_d = 1'b0;
          state_d   = StResp;
        end else if (timeout_hit) begin
          mem_req_d = 1'b0;
          state_d   = StDone;
          fault_d   = FaultTimeout;
          rdata_d   = '0;
        end
      end
      StResp: begin
        cnt_d = cnt_q + 1'b1;
        if (mem_rvalid) begin
          state_d = StDone;
          fault_d = FaultOk;
          rdata_d = we_q ? 32'h0 : lane_rdata;
        end else if (timeout_hit) begin
          state_d = StDone;
          fault_d = FaultTimeout;
          rdata_d = '0;
        end
      end
      StDone: begin
        state_d = StIdle;
        fault_d = FaultOk;
        rdata_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      we_q        <= 1'b0;
      f3_q        <= 3'b000;
      off_q       <= 2'b00;
      cnt_q       <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wstrb_q <= '0;
      mem_wdata_q <= '0;
      fault_q     <= FaultOk;
      rdata_q     <= '0;
    end else begin
      state_q     <= state_d;
      we_q        <= we_d;
      f3_q        <= f3_d;
      off_q       <= off_d;
      cnt_q       <= cnt_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wstrb_q <= mem_wstrb_d;
      mem_wdata_q <= mem_wdata_d;
      fault_q     <= fault_d;
      rdata_q     <= rdata_d;
    end
  end

  assign stall     = (idle && ex_valid) || (state_q == StReq) || (state_q == StResp);
  assign done      = (state_q == StDone);
  assign fault     = fault_q;
  assign rdata     = rdata_q;
  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wstrb = mem_wstrb_q;
  assign mem_wdata = mem_wdata_q;

endmodule
